bist_response_analyzer: RTL and testbench

BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

---
 rtl/bist_response_analyzer.sv | 156 +++++++++++++++
 tb/tb_bist_response_analyzer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// bist_response_analyzer
//
// Compacts the scan-out stream of a circuit under test into a 16-bit MISR
// signature and compares it against a stored golden signature. A session is
// started with a start pulse, accepts SCAN_CHAIN_LENGTH*TOTAL_PATTERNS valid
// scan-out bits, spends one cycle comparing, then parks in DONE with the
// verdict held until the next start or reset.
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   rst          synchronous active-high reset
//   start        session-start pulse, honoured only in IDLE or DONE
//   golden_load  sampled with start; 1 makes this session's signature golden
//   sdo_valid    cut_sdo carries a valid scan-out bit this cycle
//   cut_sdo      scan-out data from the CUT chain
//   busy         high while compacting or comparing
//   bistdone     high once the session verdict is valid
//   bistpass     session verdict, valid while bistdone is high
//   signature    current MISR contents
//   golden_valid high once a golden signature has been stored
// -----------------------------------------------------------------------------
module bist_response_analyzer #(
   parameter int          SCAN_CHAIN_LENGTH = 16,
   parameter int          TOTAL_PATTERNS    = 4,
   parameter logic [15:0] POLY              = 16'h100B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        golden_load,
   input  logic        sdo_valid,
   input  logic        cut_sdo,
   output logic        busy,
   output logic        bistdone,
   output logic        bistpass,
   output logic [15:0] signature,
   output logic        golden_valid
);

   localparam int TOTAL_BITS = SCAN_CHAIN_LENGTH * TOTAL_PATTERNS;
   // One extra count of headroom so the counter never wraps on the final bit.
   localparam int CNT_W      = (TOTAL_BITS < 1) ? 1 : $clog2(TOTAL_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPACT = 2'd1;
   localparam logic [1:0] COMPARE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   logic [1:0]       state_q,       state_d;
   logic [15:0]      misr_q,        misr_d;
   logic [CNT_W-1:0] bitCount_q,    bitCount_d;
   logic [15:0]      golden_q,      golden_d;
   logic             goldenValid_q, goldenValid_d;
   logic             load_q,        load_d;
   logic             done_q,        done_d;
   logic             pass_q,        pass_d;
   logic [15:0]      misrStep;

   // One MISR shift: multiply by x modulo the feedback polynomial, then fold
   // the incoming scan bit into the lowest stage.
   always_comb begin
      misrStep = {misr_q[14:0], 1'b0}
               ^ (misr_q[15] ? POLY : 16'h0000)
               ^ {15'b0, cut_sdo};
   end

   // Next-state logic for the session FSM and all datapath registers. start is
   // only looked at in IDLE and DONE, so a stray pulse mid-session is ignored.
   always_comb begin
      state_d       = state_q;
      misr_d        = misr_q;
      bitCount_d    = bitCount_q;
      golden_d      = golden_q;
      goldenValid_d = goldenValid_q;
      load_d        = load_q;
      done_d        = done_q;
      pass_d        = pass_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               misr_d     = 16'h0000;
               bitCount_d = '0;
               load_d     = golden_load;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               state_d    = COMPACT;
            end
         end

         COMPACT: begin
            if (sdo_valid) begin
               misr_d     = misrStep;
               bitCount_d = bitCount_q + CNT_W'(1);
               if (bitCount_q == LAST_BIT) begin
                  state_d = COMPARE;
               end
            end
         end

         COMPARE: begin
            // Without a stored golden value the first session becomes the
            // reference, exactly as if golden_load had been requested.
            if (load_q || !goldenValid_q) begin
               golden_d      = misr_q;
               goldenValid_d = 1'b1;
               pass_d        = 1'b1;
            end else begin
               pass_d = (misr_q == golden_q);
            end
            done_d  = 1'b1;
            state_d = DONE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset is the only thing that forgets the golden value;
   // starting a new session leaves it intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         misr_q        <= 16'h0000;
         bitCount_q    <= '0;
         golden_q      <= 16'h0000;
         goldenValid_q <= 1'b0;
         load_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         misr_q        <= misr_d;
         bitCount_q    <= bitCount_d;
         golden_q      <= golden_d;
         goldenValid_q <= goldenValid_d;
         load_q        <= load_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
      end
   end

   // Output decode; busy covers the compaction and the single compare cycle.
   always_comb begin
      busy         = (state_q == COMPACT) || (state_q == COMPARE);
      bistdone     = done_q;
      bistpass     = pass_q;
      signature    = misr_q;
      golden_valid = goldenValid_q;
   end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_response_analyzer
//
// Self-checking bench for bist_response_analyzer with default parameters
// (64 bits per session). Expected signatures come from polynomial division of
// the scan stream by x^16 + POLY; the golden/verdict behaviour is tracked by a
// small session-level model.
// -----------------------------------------------------------------------------
module tb_bist_response_analyzer;

   localparam int          NBITS = 64;
   localparam logic [15:0] POLY  = 16'h100B;

   logic        clk;
   logic        rst;
   logic        start;
   logic        golden_load;
   logic        sdo_valid;
   logic        cut_sdo;
   logic        busy;
   logic        bistdone;
   logic        bistpass;
   logic [15:0] signature;
   logic        golden_valid;

   int checks;
   int errors;

   // Reference golden state at session granularity.
   logic [15:0] goldenModel;
   logic        goldenValidModel;

   logic [NBITS-1:0] streamA;
   logic [NBITS-1:0] streamB;
   logic [NBITS-1:0] s;

   bist_response_analyzer #(
      .SCAN_CHAIN_LENGTH(16),
      .TOTAL_PATTERNS   (4),
      .POLY             (POLY)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .golden_load (golden_load),
      .sdo_valid   (sdo_valid),
      .cut_sdo     (cut_sdo),
      .busy        (busy),
      .bistdone    (bistdone),
      .bistpass    (bistpass),
      .signature   (signature),
      .golden_valid(golden_valid)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Signature of a stream: bit i (i-th accepted bit) is the coefficient of
   // x^(NBITS-1-i); the MISR holds that polynomial modulo x^16 + POLY.
   function automatic logic [15:0] modelSignature(input logic [NBITS-1:0] stream);
      logic [NBITS-1:0] m;
      logic [16:0]      gen;
      gen = {1'b1, POLY};
      m   = '0;
      for (int i = 0; i < NBITS; i++) m[NBITS-1-i] = stream[i];
      for (int d = NBITS-1; d >= 16; d--) begin
         if (m[d]) m[d -: 17] = m[d -: 17] ^ gen;
      end
      return m[15:0];
   endfunction

   // Advance one clock; outputs are sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One full session. gapMode 0: contiguous bits; 1: valid/idle alternating;
   // 2: random idle gaps. A start pulse rides along with bit glitchAt.
   task automatic applyStimulus(input logic load, input logic [NBITS-1:0] stream,
                                input int gapMode, input int glitchAt,
                                input string tag);
      logic [15:0] expSig;
      logic        expPass;
      int          busyCount;
      int          expBusy;
      expSig = modelSignature(stream);

      start       = 1'b1;
      golden_load = load;
      sdo_valid   = 1'b0;
      cut_sdo     = 1'($urandom);
      tick();
      start       = 1'b0;
      golden_load = 1'($urandom);
      checkOutput({tag, "_startBusy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_startDone"}, 32'(bistdone), 32'd0);
      checkOutput({tag, "_startPass"}, 32'(bistpass), 32'd0);
      checkOutput({tag, "_startSig"}, 32'(signature), 32'd0);

      busyCount = 1;
      expBusy   = 1;
      for (int i = 0; i < NBITS; i++) begin
         if ((gapMode == 1 && i > 0) || (gapMode == 2 && $urandom_range(0, 2) == 0)) begin
            sdo_valid = 1'b0;
            cut_sdo   = 1'($urandom);
            tick();
            busyCount += int'(busy);
            expBusy++;
         end
         sdo_valid = 1'b1;
         cut_sdo   = stream[i];
         start     = (i == glitchAt);
         tick();
         start = 1'b0;
         busyCount += int'(busy);
         expBusy++;
      end

      // The last bit has been accepted: one compare cycle before the verdict.
      sdo_valid = 1'b0;
      checkOutput({tag, "_cmpDone"}, 32'(bistdone), 32'd0);
      checkOutput({tag, "_cmpBusy"}, 32'(busy), 32'd1);
      tick();
      busyCount += int'(busy);

      if (load || !goldenValidModel) begin
         goldenModel      = expSig;
         goldenValidModel = 1'b1;
         expPass          = 1'b1;
      end else begin
         expPass = (expSig == goldenModel);
      end

      checkOutput({tag, "_done"}, 32'(bistdone), 32'd1);
      checkOutput({tag, "_busyEnd"}, 32'(busy), 32'd0);
      checkOutput({tag, "_busyCycles"}, 32'(busyCount), 32'(expBusy));
      checkOutput({tag, "_sig"}, 32'(signature), 32'(expSig));
      checkOutput({tag, "_pass"}, 32'(bistpass), 32'(expPass));
      checkOutput({tag, "_gvalid"}, 32'(golden_valid), 32'(goldenValidModel));

      // DONE holds the result regardless of scan traffic.
      for (int k = 0; k < 3; k++) begin
         sdo_valid = 1'b1;
         cut_sdo   = 1'($urandom);
         tick();
      end
      sdo_valid = 1'b0;
      checkOutput({tag, "_holdSig"}, 32'(signature), 32'(expSig));
      checkOutput({tag, "_holdDone"}, 32'(bistdone), 32'd1);
      checkOutput({tag, "_holdPass"}, 32'(bistpass), 32'(expPass));
   endtask

   // Directed sequence of sessions, resets and corner cases.
   initial begin
      checks           = 0;
      errors           = 0;
      goldenModel      = 16'h0000;
      goldenValidModel = 1'b0;
      rst              = 1'b1;
      start            = 1'b0;
      golden_load      = 1'b0;
      sdo_valid        = 1'b0;
      cut_sdo          = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(bistdone), 32'd0);
      checkOutput("rst_pass", 32'(bistpass), 32'd0);
      checkOutput("rst_sig", 32'(signature), 32'd0);
      checkOutput("rst_gvalid", 32'(golden_valid), 32'd0);

      // Idle with traffic and no start stays idle.
      sdo_valid = 1'b1;
      cut_sdo   = 1'b1;
      tick();
      sdo_valid = 1'b0;
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_sig", 32'(signature), 32'd0);

      applyStimulus(1'b0, '0, 0, -1, "allZero");
      s = '0; s[NBITS-1] = 1'b1;
      applyStimulus(1'b0, s, 0, -1, "lastOne");
      applyStimulus(1'b0, '0, 0, -1, "goldenKept");
      s = '0; s[48] = 1'b1;
      applyStimulus(1'b0, s, 0, -1, "bit48");
      s = '0; s[47] = 1'b1;
      applyStimulus(1'b0, s, 0, -1, "bit47");

      s = {$urandom, $urandom};
      applyStimulus(1'b0, s, 0, -1, "rndContig");
      applyStimulus(1'b0, s, 1, -1, "rndToggle");
      applyStimulus(1'b0, s, 2, 20, "rndGlitch");

      // Reset in the middle of compaction aborts the session.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         sdo_valid = 1'b1;
         cut_sdo   = 1'($urandom);
         tick();
      end
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst              = 1'b0;
      start            = 1'b0;
      sdo_valid        = 1'b0;
      goldenModel      = 16'h0000;
      goldenValidModel = 1'b0;
      checkOutput("midRst_busy", 32'(busy), 32'd0);
      checkOutput("midRst_gvalid", 32'(golden_valid), 32'd0);
      checkOutput("midRst_done", 32'(bistdone), 32'd0);
      checkOutput("midRst_sig", 32'(signature), 32'd0);

      // Golden overwrite after a failing set.
      streamA = {$urandom, $urandom};
      streamB = {$urandom, $urandom};
      applyStimulus(1'b0, streamA, 0, -1, "goldA");
      applyStimulus(1'b0, streamB, 0, -1, "failB");
      applyStimulus(1'b1, streamB, 0, -1, "loadB");
      applyStimulus(1'b0, streamB, 2, -1, "rerunB");
      applyStimulus(1'b0, streamA, 0, -1, "againA");

      for (int n = 0; n < 4; n++) begin
         s = {$urandom, $urandom};
         applyStimulus(1'($urandom_range(0, 3) == 0), s, 2, -1, "rndLoop");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
